// File: rtl/pipeline_control.sv
// Purpose: turns EX/MEM hazard codes, load flag and branch resolution into forwarding selects, load-use stalls and flushes.
// Latency: stall/bubble/flush are combinational in the same cycle; forwarding selects are registered (1 cycle).
// Backpressure: none accepted; the block itself stalls IF/ID for one cycle on a load-use hazard.
module pipeline_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       hazard_ex,
  input  logic [3:0]       hazard_mem,
  input  logic             ex_is_load,
  input  logic             branch_taken,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_if,
  output logic             flush_id,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [2:0] FROM_EX_RS1  = 3'b001;
  localparam logic [2:0] FROM_EX_RS2  = 3'b010;
  localparam logic [2:0] FROM_MEM_RS1 = 3'b011;
  localparam logic [2:0] FROM_MEM_RS2 = 3'b100;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {RUN, LOAD_STALL, FLUSH} state_t;

  state_t     state;
  state_t     state_nxt;
  logic       ex_rs1;
  logic       ex_rs2;
  logic       mem_rs1;
  logic       mem_rs2;
  logic       ex_hit;
  logic [1:0] sel_a_nxt;
  logic [1:0] sel_b_nxt;

  // Each detector only reports hazards belonging to its own source; other codes mean "none".
  assign ex_rs1  = hazard_ex[3]  && (hazard_ex[2:0]  == FROM_EX_RS1);
  assign ex_rs2  = hazard_ex[3]  && (hazard_ex[2:0]  == FROM_EX_RS2);
  assign mem_rs1 = hazard_mem[3] && (hazard_mem[2:0] == FROM_MEM_RS1);
  assign mem_rs2 = hazard_mem[3] && (hazard_mem[2:0] == FROM_MEM_RS2);
  assign ex_hit  = ex_rs1 || ex_rs2;

  // Forwarding select candidates: EX holds the youngest producer, so it wins over MEM.
  always_comb begin
    sel_a_nxt = SEL_RF;
    sel_b_nxt = SEL_RF;
    if (ex_rs1)       sel_a_nxt = SEL_EX;
    else if (mem_rs1) sel_a_nxt = SEL_MEM;
    if (ex_rs2)       sel_b_nxt = SEL_EX;
    else if (mem_rs2) sel_b_nxt = SEL_MEM;
  end

  // State register; reset aborts any stall or flush in progress.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Next state: a taken branch beats load-use; stall and flush slots each last one cycle.
  always_comb begin
    state_nxt = RUN;
    case (state)
      RUN: begin
        if (branch_taken)             state_nxt = FLUSH;
        else if (ex_hit && ex_is_load) state_nxt = LOAD_STALL;
        else                          state_nxt = RUN;
      end
      LOAD_STALL: state_nxt = branch_taken ? FLUSH : RUN;
      FLUSH:      state_nxt = branch_taken ? FLUSH : RUN;
      default:    state_nxt = RUN;
    endcase
  end

  // Control outputs: load-use stall only from RUN; a taken branch flushes from any state.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_if  = 1'b0;
    flush_id  = 1'b0;
    if (!rst) begin
      flush_if = branch_taken;
      flush_id = branch_taken;
      if (state == RUN && !branch_taken && ex_hit && ex_is_load) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

  // Registered selects: cleared when the slot entering EX is a bubble or a flushed instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_sel <= SEL_RF;
      fwd_b_sel <= SEL_RF;
    end else if (branch_taken || stall_if || state == FLUSH) begin
      fwd_a_sel <= SEL_RF;
      fwd_b_sel <= SEL_RF;
    end else begin
      fwd_a_sel <= sel_a_nxt;
      fwd_b_sel <= sel_b_nxt;
    end
  end

  // Saturating performance counters, one count per stall cycle / flush event.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_if && stall_count != '1) stall_count <= stall_count + CNT_ONE;
      if (flush_if && flush_count != '1) flush_count <= flush_count + CNT_ONE;
    end
  end

endmodule
